instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the field decoder. Holds the PC and issues

---
 rtl/riu_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/riu_pkg.sv
// Shared fetch-path types and constants.
//   XLEN / ILEN   : address and instruction widths
//   INSTR_BYTES   : PC increment per fetched word
//   fetch_entry_t : one buffered instruction with the address it came from
//   pc_next()     : sequential PC step (wraps naturally at 2^XLEN)
package riu_pkg;
  localparam int XLEN        = 32;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect from
// execute, and the valid/ready instruction stream to the decoder.
//   master : the fetch unit side
//   slave  : the environment side (memory, execute, decoder)
interface instr_fetch_unit_if;
  logic                       imem_req;
  logic [riu_pkg::XLEN-1:0]   imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [riu_pkg::ILEN-1:0]   imem_rdata;
  logic                       redirect_valid;
  logic [riu_pkg::XLEN-1:0]   redirect_pc;
  logic                       instr_valid;
  logic                       instr_ready;
  logic [riu_pkg::ILEN-1:0]   instr;
  logic [riu_pkg::XLEN-1:0]   instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write entry_i (caller guarantees space unless popping too)
//   pop_i     : drop head (caller guarantees non-empty)
//   flush_i   : discard all entries; wins over push/pop
//   head_o    : oldest entry, count_o / full_o / empty_o : occupancy
module fetch_fifo
  import riu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // On full push+pop wr_q == rd_q: the old head is consumed at this edge
      // and its slot takes the new word.
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= inc(wr_q);
      end
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, request credit, response tagging and redirect
// handling in front of the decoder.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master (imem req/gnt/rvalid, redirect,
//              instr valid/ready stream)
// Requests are issued only while (inflight + buffered) < FIFO_DEPTH, so every
// response always has a FIFO slot and memory never sees backpressure.
module instr_fetch_unit
  import riu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] tag_q [FIFO_DEPTH];
  logic [TW-1:0]   tag_wr_q, tag_rd_q;

  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    fifo_head, fifo_in;
  logic            req, grant, rsp, push, pop;

  function automatic logic [TW-1:0] tinc(input logic [TW-1:0] p);
    return (p == TW'(FIFO_DEPTH - 1)) ? '0 : p + TW'(1);
  endfunction

  assign req   = !rst && (({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign grant = req && bus.imem_gnt;
  assign rsp   = bus.imem_rvalid;
  // A response in the redirect cycle belongs to the old stream.
  assign push  = rsp && (discard_q == '0) && !bus.redirect_valid;
  assign pop   = bus.instr_valid && bus.instr_ready;

  assign fifo_in = '{instr: bus.imem_rdata, pc: tag_q[tag_rd_q]};

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(grant) - CW'(rsp);
    discard_d  = discard_q;
    if (bus.redirect_valid) begin
      pc_d      = {bus.redirect_pc[XLEN-1:2], 2'b00};
      // Everything still outstanding after this edge (including a request
      // granted right now) is stale.
      discard_d = inflight_d;
    end else begin
      if (grant) pc_d = pc_next(pc_q);
      if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      // Tag queue tracks every outstanding request, stale or not, so it is
      // never flushed; dropped responses simply retire their tag.
      if (grant) begin
        tag_q[tag_wr_q] <= pc_q;
        tag_wr_q        <= tinc(tag_wr_q);
      end
      if (rsp) tag_rd_q <= tinc(tag_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full && !pop));
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (fifo_in),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = !rst && !fifo_empty;
  assign bus.instr       = rst ? '0 : fifo_head.instr;
  assign bus.instr_pc    = rst ? '0 : fifo_head.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import riu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Memory contents: a fixed hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus + memory model ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc_n     = 0;
  int    gnt_pct   = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;
  bit    rst_drv   = 1'b1;
  bit    force_rd  = 1'b0;
  logic [31:0] force_pc;

  task automatic step();
    @(posedge clk);
    cyc_n++;
    #1;
    rst = rst_drv;
    if (rst_drv) begin
      pend.delete();
      bus.imem_rvalid    = 1'b0;
      bus.redirect_valid = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc_n) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      if (force_rd) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = force_pc;
        force_rd           = 1'b0;
      end else if ($urandom_range(999) < redir_pm) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF5 : $urandom;
      end else begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom;
      end
    end
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.instr_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (bus.imem_req && bus.imem_gnt)
      pend.push_back('{addr: bus.imem_addr, due: cyc_n + $urandom_range(lat_max, lat_min)});
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    repeat (3) step();
    rst_drv = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  int          out_cnt = 0;
  int          xfers   = 0;
  bit          prev_hold = 0, post_redir = 0;
  logic [31:0] prev_pc, prev_instr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_imem_req",    32'(bus.imem_req), 32'd0);
      chk("rst_instr",       bus.instr, 32'd0);
      chk("rst_instr_pc",    bus.instr_pc, 32'd0);
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      out_cnt    = 0;
      prev_hold  = 0;
      post_redir = 0;
    end else begin
      if (post_redir) chk("redirect_bubble", 32'(bus.instr_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_pc",    bus.instr_pc, prev_pc);
        chk("hold_instr", bus.instr, prev_instr);
      end
      if (bus.imem_req) chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
      if (bus.instr_valid && bus.instr_ready) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("instr_pc", bus.instr_pc, e);
        chk("instr",    bus.instr, mem_word(e));
        exp_q.push_back(e + 32'd4);
        xfers++;
      end
      out_cnt += int'(bus.imem_req && bus.imem_gnt) - int'(bus.imem_rvalid);
      chk("credit_bound", 32'(out_cnt <= DEPTH), 32'd1);
      if (bus.redirect_valid) begin
        exp_q.delete();
        exp_q.push_back({bus.redirect_pc[31:2], 2'b00});
      end
      post_redir = bus.redirect_valid;
      prev_hold  = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      prev_pc    = bus.instr_pc;
      prev_instr = bus.instr;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int first_v, ng, x0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;

    // 1: straight-line stream with single-cycle memory
    gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0;
    do_reset();
    first_v = -1; ng = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) begin
        chk("t1_first_req",  32'(bus.imem_req), 32'd1);
        chk("t1_first_addr", bus.imem_addr, RESET_PC);
      end
      if (bus.imem_req && bus.imem_gnt) begin
        chk("t1_addr_seq", bus.imem_addr, RESET_PC + 32'(4 * ng));
        ng++;
      end
      if (first_v < 0 && bus.instr_valid) first_v = k;
    end
    chk("t1_first_valid_cycle", 32'(first_v), 32'd2);

    // 2: decoder stall fills the buffer, then drains in order
    do_reset();
    rdy_pct = 0;
    repeat (10) step();
    chk("t2_req_off",   32'(bus.imem_req), 32'd0);
    chk("t2_valid",     32'(bus.instr_valid), 32'd1);
    chk("t2_pc",        bus.instr_pc, RESET_PC);
    chk("t2_no_pend",   32'(pend.size()), 32'd0);
    rdy_pct = 100;
    x0 = xfers;
    repeat (10) step();
    chk("t2_progress", 32'(xfers - x0 >= 4), 32'd1);

    // 3: redirect with two requests outstanding
    do_reset();
    lat_min = 4; lat_max = 4;
    repeat (2) step();
    chk("t3_two_inflight", 32'(pend.size()), 32'd2);
    force_pc = 32'h0000_0103; force_rd = 1'b1;
    step();
    lat_min = 1; lat_max = 1;
    step();
    chk("t3_new_addr", bus.imem_addr, 32'h0000_0100);
    x0 = xfers;
    repeat (20) step();
    chk("t3_progress", 32'(xfers > x0), 32'd1);

    // 4: redirect coinciding with a grant and a response
    do_reset();
    step();
    force_pc = 32'h0000_0200; force_rd = 1'b1;
    step();
    chk("t4_rvalid_same_cycle", 32'(bus.imem_rvalid), 32'd1);
    chk("t4_grant_same_cycle",  32'(bus.imem_req && bus.imem_gnt), 32'd1);
    x0 = xfers;
    repeat (20) step();
    chk("t4_progress", 32'(xfers > x0), 32'd1);

    // 5: random traffic
    gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4; redir_pm = 25;
    x0 = xfers;
    repeat (10000) step();
    redir_pm = 0;
    repeat (20) step();
    chk("t5_progress", 32'(xfers - x0 > 1000), 32'd1);

    // 6: reset mid-stream with two requests outstanding
    gnt_pct = 100; rdy_pct = 100; lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && pend.size() != 2; k++) step();
    chk("t6_two_inflight", 32'(pend.size()), 32'd2);
    rst_drv = 1'b1;
    repeat (2) step();
    rst_drv = 1'b0;
    lat_min = 1; lat_max = 1;
    step();
    chk("t6_restart_req",  32'(bus.imem_req), 32'd1);
    chk("t6_restart_addr", bus.imem_addr, RESET_PC);
    x0 = xfers;
    repeat (20) step();
    chk("t6_progress", 32'(xfers > x0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
